// File: rtl/pc_sequencer_if.sv
// Request/status bundle between instruction decode and the program sequencer.
// Decode drives the redirect requests and reads back the fetch address and status.
interface pc_sequencer_if #(
  parameter int Psize = 4
);
  logic             hold;
  logic             jump;
  logic             call;
  logic             ret;
  logic             halt;
  logic             resume;
  logic [Psize-1:0] target;
  logic [Psize-1:0] progAddr;
  logic             flush;
  logic             halted;
  logic             stackErr;

  modport master (
    output hold, jump, call, ret, halt, resume, target,
    input  progAddr, flush, halted, stackErr
  );

  modport slave (
    input  hold, jump, call, ret, halt, resume, target,
    output progAddr, flush, halted, stackErr
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: owns the fetch address, a small return-address stack and the
// run/halt state, and pulses flush in the cycle after any taken redirect.
module pc_sequencer #(
  parameter int Psize      = 4,
  parameter int StackDepth = 4
) (
  input logic          clk,
  input logic          Reset,
  pc_sequencer_if.slave bus
);

  localparam int SpW  = $clog2(StackDepth + 1);
  localparam int IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;
  localparam logic [SpW-1:0] SpMax = SpW'(StackDepth);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q;
  logic [Psize-1:0] pc_q;
  logic [SpW-1:0]   sp_q;
  logic             flush_q;
  logic             halted_q;
  logic             err_q;
  logic [Psize-1:0] stack_q [0:(2**IdxW)-1];

  logic             push_en;
  logic [SpW-1:0]   sp_dec;
  logic [IdxW-1:0]  push_idx;
  logic [IdxW-1:0]  pop_idx;

  function automatic logic [Psize-1:0] next_addr(input logic [Psize-1:0] a);
    return a + Psize'(1);
  endfunction

  // A push happens only for a call that wins priority and finds room on the stack.
  always_comb begin
    push_en  = (state_q == RUN) && !bus.halt && !bus.hold && !bus.ret &&
               bus.call && (sp_q != SpMax);
    sp_dec   = sp_q - SpW'(1);
    push_idx = sp_q[IdxW-1:0];
    pop_idx  = sp_dec[IdxW-1:0];
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= next_addr(pc_q);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      sp_q     <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (bus.halt) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (bus.hold) begin
          end else if (bus.ret) begin
            if (sp_q != '0) begin
              pc_q    <= stack_q[pop_idx];
              sp_q    <= sp_dec;
              flush_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
              pc_q  <= next_addr(pc_q);
            end
          end else if (bus.call) begin
            if (sp_q != SpMax) begin
              pc_q    <= bus.target;
              sp_q    <= sp_q + SpW'(1);
              flush_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
              pc_q  <= next_addr(pc_q);
            end
          end else if (bus.jump) begin
            pc_q    <= bus.target;
            flush_q <= 1'b1;
          end else begin
            pc_q <= next_addr(pc_q);
          end
        end
        // Resume steps past the halting instruction on the same edge.
        HALT: begin
          if (bus.resume) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            pc_q     <= next_addr(pc_q);
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.progAddr = pc_q;
  assign bus.flush    = flush_q;
  assign bus.halted   = halted_q;
  assign bus.stackErr = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a queue-based reference model.
module tb_pc_sequencer;

  localparam int PS    = 4;
  localparam int DEPTH = 2;
  localparam int AMOD  = 1 << PS;

  logic clk;
  logic Reset;
  pc_sequencer_if #(.Psize(PS)) bus ();

  pc_sequencer #(.Psize(PS), .StackDepth(DEPTH)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int m_pc, m_flush, m_halted, m_err;
  int stk[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect4(input string nm, input int pc, input int fl, input int hl, input int er);
    chk({nm, ".progAddr"}, 32'(bus.progAddr), pc);
    chk({nm, ".flush"},    32'(bus.flush),    fl);
    chk({nm, ".halted"},   32'(bus.halted),   hl);
    chk({nm, ".stackErr"}, 32'(bus.stackErr), er);
  endtask

  task automatic model_reset();
    m_pc = 0; m_flush = 0; m_halted = 0; m_err = 0;
    stk.delete();
  endtask

  // Reference behaviour written straight from the priority rules.
  task automatic model_update();
    int nxt;
    nxt = (m_pc + 1) % AMOD;
    m_flush = 0;
    if (m_halted != 0) begin
      if (bus.resume) begin m_halted = 0; m_pc = nxt; end
    end else if (bus.halt) begin
      m_halted = 1;
    end else if (bus.hold) begin
    end else if (bus.ret) begin
      if (stk.size() > 0) begin m_pc = stk.pop_back(); m_flush = 1; end
      else begin m_err = 1; m_pc = nxt; end
    end else if (bus.call) begin
      if (stk.size() < DEPTH) begin stk.push_back(nxt); m_pc = int'(bus.target); m_flush = 1; end
      else begin m_err = 1; m_pc = nxt; end
    end else if (bus.jump) begin
      m_pc = int'(bus.target); m_flush = 1;
    end else begin
      m_pc = nxt;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.progAddr", 32'(bus.progAddr), m_pc);
      chk("model.flush",    32'(bus.flush),    m_flush);
      chk("model.halted",   32'(bus.halted),   m_halted);
      chk("model.stackErr", 32'(bus.stackErr), m_err);
    end
  end

  task automatic set_in(input logic h, input logic j, input logic c, input logic r,
                        input logic ha, input logic re, input logic [PS-1:0] t);
    bus.hold = h; bus.jump = j; bus.call = c; bus.ret = r;
    bus.halt = ha; bus.resume = re; bus.target = t;
  endtask

  task automatic step(input logic h, input logic j, input logic c, input logic r,
                      input logic ha, input logic re, input logic [PS-1:0] t);
    set_in(h, j, c, r, ha, re, t);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, '0);
    @(posedge clk);
    #2 Reset = 1'b1;
    model_reset();
    #2 Reset = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, '0);
    model_reset();

    // Free-running count with wrap.
    do_reset();
    expect4("reset", 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      idle();
      chk("count.progAddr", 32'(bus.progAddr), k % 16);
      chk("count.flush", 32'(bus.flush), 0);
    end

    // Hold freezes the address.
    do_reset();
    for (int k = 0; k < 6; k++) idle();
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0, 0, 0, '0);
      expect4("hold", 6, 0, 0, 0);
    end
    idle();
    expect4("hold.release", 7, 0, 0, 0);

    // Call then return.
    do_reset();
    for (int k = 0; k < 3; k++) idle();
    step(0, 0, 1, 0, 0, 0, 4'd10);
    expect4("call", 10, 1, 0, 0);
    idle();
    expect4("call+1", 11, 0, 0, 0);
    idle();
    expect4("call+2", 12, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, '0);
    expect4("ret", 4, 1, 0, 0);
    idle();
    expect4("ret+1", 5, 0, 0, 0);

    // call+ret together: only ret (underflow here), call discarded.
    step(0, 0, 1, 1, 0, 0, 4'd2);
    expect4("callret", 6, 0, 0, 1);

    // Nested calls overflow, then returns underflow.
    do_reset();
    step(0, 0, 1, 0, 0, 0, 4'd8);
    expect4("nest.call1", 8, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 4'd9);
    expect4("nest.call2", 9, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 4'd10);
    expect4("nest.call3", 10, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, '0);
    expect4("nest.ret1", 9, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0, '0);
    expect4("nest.ret2", 1, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0, '0);
    expect4("nest.ret3", 2, 0, 0, 1);

    // Return address pushed from the last address wraps to 0.
    do_reset();
    for (int k = 0; k < 15; k++) idle();
    step(0, 0, 1, 0, 0, 0, 4'd3);
    expect4("wrap.call", 3, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, '0);
    expect4("wrap.ret", 0, 1, 0, 0);

    // Halt ignores everything except resume.
    do_reset();
    for (int k = 0; k < 5; k++) idle();
    step(0, 0, 0, 0, 1, 0, '0);
    expect4("halt", 5, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 1, 1, 0, 4'd12);
      expect4("halt.ignore", 5, 0, 1, 0);
    end
    step(0, 0, 0, 0, 0, 1, '0);
    expect4("resume", 6, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, '0);
    expect4("resume.run", 7, 0, 0, 0);

    // Back-to-back jumps keep flush high.
    step(0, 1, 0, 0, 0, 0, 4'd2);
    expect4("jump1", 2, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 4'd13);
    expect4("jump2", 13, 1, 0, 0);

    // Asynchronous reset mid-call.
    do_reset();
    step(0, 0, 1, 0, 0, 0, 4'd9);
    expect4("pre.reset", 9, 1, 0, 0);
    set_in(0, 0, 1, 0, 0, 0, 4'd5);
    #1 Reset = 1'b1;
    model_reset();
    #1;
    expect4("async.reset", 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, '0);
    #1 Reset = 1'b0;
    step(0, 0, 0, 1, 0, 0, '0);
    expect4("post.reset.ret", 1, 0, 0, 1);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #1 Reset = 1'b1;
        model_reset();
        #1 Reset = 1'b0;
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
           PS'($urandom_range(0, AMOD - 1)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program sequencer that owns the program counter for the picoNISC core.
- Each cycle it chooses the next fetch address: increment, hold, jump, call or return.
- Holds a small return-address stack and a halt/resume state machine, and flags pipeline flushes on redirects.
- Sits between instruction decode and program memory and replaces the bare counter as the address source.

Parameters:
- Psize, 4, program address width in bits; address space is 2^Psize words.
- StackDepth, 4, number of return-stack entries (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- hold  input  1  stall request; progAddr is frozen while asserted.
- jump  input  1  load progAddr from target.
- call  input  1  push return address, then load progAddr from target.
- ret  input  1  pop return address into progAddr.
- halt  input  1  enter HALT at the current address.
- resume  input  1  leave HALT.
- target  input  Psize  jump/call destination.
- progAddr  output  Psize  current fetch address (registered).
- flush  output  1  one-cycle pulse in the cycle after a redirect is taken.
- halted  output  1  high while in HALT.
- stackErr  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous, any time, mid-operation included):
  - progAddr=0, state=RUN, sp=0, flush=0, halted=0, stackErr=0.
  - Stack contents are don't-care.
- States:
  - RUN: normal sequencing.
  - HALT: progAddr frozen, halted=1.
- RUN priority, evaluated at the rising edge (highest first):
  - halt: go to HALT; progAddr unchanged.
  - hold: progAddr unchanged; stack unchanged.
  - ret:
    - sp>0: progAddr<=stack[sp-1], sp<=sp-1, flush pulses.
    - sp==0: underflow; stackErr<=1, progAddr<=progAddr+1, no flush.
  - call:
    - sp<StackDepth: stack[sp]<=progAddr+1, sp<=sp+1, progAddr<=target, flush pulses.
    - sp==StackDepth: overflow; stackErr<=1, no push, no redirect, progAddr<=progAddr+1.
  - jump: progAddr<=target, flush pulses.
  - none of the above: progAddr<=progAddr+1.
- Lower-priority requests in the same cycle are discarded, not queued. Example: call+ret together executes ret only.
- HALT:
  - All inputs except resume are ignored; no flush is generated.
  - resume: state<=RUN and progAddr<=progAddr+1 on the same edge, so execution continues after the halting instruction.
  - resume while in RUN is ignored.
- Latency:
  - Redirects take effect one cycle after the request is sampled; progAddr equals target in the cycle after the edge.
  - flush is high for exactly that one cycle, then returns to 0.
  - A redirect taken on consecutive cycles keeps flush high in both following cycles.
- Arithmetic:
  - All address increments are modulo 2^Psize; 2^Psize-1 wraps to 0.
  - A return address pushed from the last address is 0.
- sp width: clog2(StackDepth+1) bits; it never exceeds StackDepth and never goes below 0.
- stackErr stays set until Reset.
- The flush pulse is registered and cleared by Reset.

Test Plan:
- Psize=4, no requests, 40 cycles after Reset falls -> progAddr runs 0,1,…,15,0,1,…; flush stays 0.
- hold high for 5 cycles at progAddr=6 -> progAddr stays 6 for 5 cycles, then 7; stack untouched.
- At progAddr=3, call with target=10, then ret at progAddr=12 -> progAddr 10, 11, 12, then 4; flush high for one cycle after each redirect.
- StackDepth=2: three nested calls (targets 8, 9, 10) -> third call gives stackErr=1 and progAddr increments. Then ret, ret, ret -> returns to the correct addresses, third ret is an underflow, stackErr stays 1.
- halt at progAddr=5, then jump/call/hold for 3 cycles, then resume -> progAddr stays 5 with halted=1; after resume progAddr=6, halted=0, no flush.
- Reset asserted mid-call at sp=1 with progAddr=9 -> outputs go to 0 immediately (asynchronously). After release the sequence restarts at 0 with sp=0, and a following ret is an underflow.
